// File: rtl/irq_capture_encoder8_if.sv
// rtl/irq_capture_encoder8_if.sv - grant code handshake between capture stage and consumer
interface irq_capture_encoder8_if #(
  parameter int CODE_W = 3
);
  logic [CODE_W-1:0] q;
  logic              valid;
  logic              ack;

  modport master (output q, output valid, input ack);
  modport slave  (input q, input valid, output ack);
endinterface

// File: rtl/irq_capture_encoder8.sv
// rtl/irq_capture_encoder8.sv - edge-captured sticky request lines encoded to one granted code per event
module irq_capture_encoder8 #(
  parameter int WIDTH    = 8,
  parameter int CODE_W   = 3,
  parameter int HI_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [WIDTH-1:0]        i,
  irq_capture_encoder8_if.master  bus,
  output logic [WIDTH-1:0]        pending,
  output logic                    overflow
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [WIDTH-1:0]  i_d;
  logic [WIDTH-1:0]  rise;
  logic [WIDTH-1:0]  clr;
  logic [WIDTH-1:0]  pending_nxt;
  logic              ovf_set;
  logic [CODE_W-1:0] prio;

  always_comb begin
    rise        = i & ~i_d;
    clr         = '0;
    if (bus.valid && bus.ack) clr = WIDTH'(1) << bus.q;
    // a fresh edge on the bit being acked keeps it pending for a later grant
    pending_nxt = (pending & ~clr) | rise;
    ovf_set     = |(rise & pending & ~clr);
  end

  always_comb begin
    prio = '0;
    for (int n = 0; n < WIDTH; n++) begin
      if (HI_FIRST != 0) begin
        if (pending[n]) prio = CODE_W'(n);
      end else begin
        if (pending[WIDTH-1-n]) prio = CODE_W'(WIDTH-1-n);
      end
    end
  end

  always_ff @(posedge clk) begin
    // i_d tracks i through reset and disable so lines already high never fire on release
    i_d <= i;
    if (!rst_n || !enable) begin
      pending   <= '0;
      overflow  <= 1'b0;
      bus.q     <= '0;
      bus.valid <= 1'b0;
      state     <= IDLE;
    end else begin
      pending <= pending_nxt;
      if (ovf_set) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (pending != '0) begin
            bus.q     <= prio;
            bus.valid <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (bus.ack) begin
            bus.valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          bus.valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_capture_encoder8.sv
// tb/tb_irq_capture_encoder8.sv - directed self-checking bench for irq_capture_encoder8
module tb_irq_capture_encoder8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] i;
  logic [7:0] pending;
  logic       overflow;
  int         checks = 0;
  int         failures = 0;

  irq_capture_encoder8_if #(.CODE_W(3)) bus ();

  irq_capture_encoder8 #(.WIDTH(8), .CODE_W(3), .HI_FIRST(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .i        (i),
    .bus      (bus.master),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; i = 8'hFF; bus.ack = 1'b0;
    step(); step();
    checks++; if (bus.q !== 3'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", bus.q); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL reset_pending got=%h exp=00", pending); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst_n = 1'b1;
    step(); step();
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL reset_release_pending got=%h exp=00", pending); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid got=%b exp=0", bus.valid); end
    i = 8'h00;
    step();
  endtask

  task automatic test_single();
    i = 8'h04;
    step();
    checks++; if (pending !== 8'h04) begin failures++; $display("FAIL single_pending got=%h exp=04", pending); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL single_valid_e0 got=%b exp=0", bus.valid); end
    step();
    checks++; if (bus.valid !== 1'b1) begin failures++; $display("FAIL single_valid_e1 got=%b exp=1", bus.valid); end
    checks++; if (bus.q !== 3'd2) begin failures++; $display("FAIL single_q got=%0d exp=2", bus.q); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL single_ack_valid got=%b exp=0", bus.valid); end
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL single_ack_pending got=%h exp=00", pending); end
    step();
    checks++; if (pending !== 8'h00 || bus.valid !== 1'b0) begin failures++; $display("FAIL single_held_level got=%h/%b exp=00/0", pending, bus.valid); end
    i = 8'h00;
    step();
  endtask

  task automatic test_priority();
    i = 8'h81;
    step();
    checks++; if (pending !== 8'h81) begin failures++; $display("FAIL prio_pending got=%h exp=81", pending); end
    step();
    checks++; if (bus.valid !== 1'b1 || bus.q !== 3'd7) begin failures++; $display("FAIL prio_first got=%b/%0d exp=1/7", bus.valid, bus.q); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0 || pending !== 8'h01) begin failures++; $display("FAIL prio_idle got=%b/%h exp=0/01", bus.valid, pending); end
    step();
    checks++; if (bus.valid !== 1'b1 || bus.q !== 3'd0) begin failures++; $display("FAIL prio_second got=%b/%0d exp=1/0", bus.valid, bus.q); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL prio_done got=%b/%h exp=0/00", bus.valid, pending); end
    i = 8'h00;
    step();
  endtask

  task automatic test_overflow();
    i = 8'h08;
    step();
    i = 8'h00;
    step();
    checks++; if (bus.valid !== 1'b1 || bus.q !== 3'd3) begin failures++; $display("FAIL ovf_grant got=%b/%0d exp=1/3", bus.valid, bus.q); end
    i = 8'h08;
    step();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    i = 8'h00; bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    checks++; if (overflow !== 1'b1 || pending !== 8'h00) begin failures++; $display("FAIL ovf_sticky got=%b/%h exp=1/00", overflow, pending); end
    enable = 1'b0;
    step();
    enable = 1'b1;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    i = 8'h20;
    step();
    i = 8'h00;
    step();
    checks++; if (bus.valid !== 1'b1 || bus.q !== 3'd5) begin failures++; $display("FAIL setwins_grant got=%b/%0d exp=1/5", bus.valid, bus.q); end
    i = 8'h20; bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    checks++; if (pending !== 8'h20) begin failures++; $display("FAIL setwins_pending got=%h exp=20", pending); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL setwins_overflow got=%b exp=0", overflow); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL setwins_idle got=%b exp=0", bus.valid); end
    step();
    checks++; if (bus.valid !== 1'b1 || bus.q !== 3'd5) begin failures++; $display("FAIL setwins_regrant got=%b/%0d exp=1/5", bus.valid, bus.q); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL setwins_done got=%b/%h exp=0/00", bus.valid, pending); end
    i = 8'h00;
    step();
  endtask

  task automatic test_enable();
    i = 8'h02;
    step();
    step();
    i = 8'h12;
    step();
    checks++; if (pending !== 8'h12 || bus.valid !== 1'b1) begin failures++; $display("FAIL en_setup got=%h/%b exp=12/1", pending, bus.valid); end
    enable = 1'b0;
    step();
    enable = 1'b1;
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL en_pending got=%h exp=00", pending); end
    checks++; if (bus.valid !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL en_valid_ovf got=%b/%b exp=0/0", bus.valid, overflow); end
    step();
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL en_reenable_pending got=%h exp=00", pending); end
    step();
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL en_reenable_valid got=%b exp=0", bus.valid); end
    i = 8'h00;
    step();
  endtask

  task automatic test_no_preempt();
    i = 8'h02;
    step();
    i = 8'h00;
    step();
    checks++; if (bus.valid !== 1'b1 || bus.q !== 3'd1) begin failures++; $display("FAIL np_grant got=%b/%0d exp=1/1", bus.valid, bus.q); end
    i = 8'h40;
    step();
    step();
    checks++; if (bus.q !== 3'd1 || pending !== 8'h42) begin failures++; $display("FAIL np_hold got=%0d/%h exp=1/42", bus.q, pending); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0 || pending !== 8'h40) begin failures++; $display("FAIL np_ack got=%b/%h exp=0/40", bus.valid, pending); end
    step();
    checks++; if (bus.valid !== 1'b1 || bus.q !== 3'd6) begin failures++; $display("FAIL np_next got=%b/%0d exp=1/6", bus.valid, bus.q); end
    bus.ack = 1'b1; i = 8'h00;
    step();
    bus.ack = 1'b0;
    i = 8'h10;
    step();
    bus.ack = 1'b1;
    step();
    checks++; if (pending !== 8'h10) begin failures++; $display("FAIL stray_ack_pending got=%h exp=10", pending); end
    checks++; if (bus.valid !== 1'b1 || bus.q !== 3'd4) begin failures++; $display("FAIL stray_ack_grant got=%b/%0d exp=1/4", bus.valid, bus.q); end
    step();
    bus.ack = 1'b0;
    checks++; if (bus.valid !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL stray_ack_done got=%b/%h exp=0/00", bus.valid, pending); end
    i = 8'h00;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_overflow();
    test_enable();
    test_no_preempt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
